// File: rtl/sap_cpu_param.sv
// Parametrised accumulator CPU: A/B/IR/PC/MAR/RAM/OUT datapath on a one-hot muxed bus, microcoded control.
// Latency: 2..5 clk per instruction (fetch T0/T1 plus 0..3 execute steps); out_valid pulses the cycle after OUT T2.
// Backpressure: none; the core free-runs until HLT and only clr leaves the halted state.
//
// Ports: clk/clr (async active-high reset); prog_we/prog_addr/prog_data load RAM only while clr or halted;
//        out_data/out_valid display port; halted, pc, a_data, b_data, ir_data, flags {carry,zero}, step are debug views.
// Note: DATA_W must be at least 4+ADDR_W so the opcode and the address operand do not overlap.
module sap_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] ir_data,
    output logic [1:0]        flags,
    output logic [2:0]        step
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot bus source positions
    localparam int SRC_PC  = 0;
    localparam int SRC_RAM = 1;
    localparam int SRC_OPR = 2;
    localparam int SRC_A   = 3;
    localparam int SRC_ALU = 4;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    step_t st, st_nxt;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] bus;
    logic [DATA_W:0]   sum;
    logic              carry, zero;

    logic [4:0] bus_sel;
    logic       mar_ld, ir_ld, pc_inc, pc_ld, a_ld, b_ld, out_ld, ram_we, flags_ld, halt_set, alu_sub;

    logic [3:0]        opcode;
    logic [3:0]        fetch_op;
    logic [ADDR_W-1:0] operand;

    assign opcode   = ir_data[DATA_W-1 -: 4];
    assign operand  = ir_data[ADDR_W-1:0];
    assign ram_rd   = ram[mar];
    assign fetch_op = ram_rd[DATA_W-1 -: 4];

    // NOP and the undefined opcodes finish right after fetch
    function automatic logic is_nop_class(input logic [3:0] op);
        return (op == 4'h0) || (op >= 4'h9 && op <= 4'hD);
    endfunction

    // ALU: subtraction is A + ~B + 1, so carry means "no borrow"
    assign sum = {1'b0, a_data} + {1'b0, (alu_sub ? ~b_data : b_data)} + (DATA_W+1)'(alu_sub);

    // Priority-free AND-OR bus: at most one source is selected per step
    assign bus = ({DATA_W{bus_sel[SRC_PC]}}  & DATA_W'(pc))
               | ({DATA_W{bus_sel[SRC_RAM]}} & ram_rd)
               | ({DATA_W{bus_sel[SRC_OPR]}} & DATA_W'(operand))
               | ({DATA_W{bus_sel[SRC_A]}}   & a_data)
               | ({DATA_W{bus_sel[SRC_ALU]}} & sum[DATA_W-1:0]);

    // Microcode: control word and next step from (step, opcode)
    always_comb begin
        bus_sel  = '0;
        mar_ld   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        out_ld   = 1'b0;
        ram_we   = 1'b0;
        flags_ld = 1'b0;
        halt_set = 1'b0;
        alu_sub  = 1'b0;
        st_nxt   = st;
        if (!halted) begin
            unique case (st)
                T0: begin
                    bus_sel[SRC_PC] = 1'b1;
                    mar_ld          = 1'b1;
                    st_nxt          = T1;
                end
                T1: begin
                    bus_sel[SRC_RAM] = 1'b1;
                    ir_ld            = 1'b1;
                    pc_inc           = 1'b1;
                    // Skip execute steps entirely for no-op words
                    st_nxt           = is_nop_class(fetch_op) ? T0 : T2;
                end
                T2: begin
                    st_nxt = T0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            bus_sel[SRC_OPR] = 1'b1;
                            mar_ld           = 1'b1;
                            st_nxt           = T3;
                        end
                        OP_LDI: begin
                            bus_sel[SRC_OPR] = 1'b1;
                            a_ld             = 1'b1;
                        end
                        OP_JMP: begin
                            bus_sel[SRC_OPR] = 1'b1;
                            pc_ld            = 1'b1;
                        end
                        OP_JC: begin
                            bus_sel[SRC_OPR] = 1'b1;
                            pc_ld            = carry;
                        end
                        OP_JZ: begin
                            bus_sel[SRC_OPR] = 1'b1;
                            pc_ld            = zero;
                        end
                        OP_OUT: begin
                            bus_sel[SRC_A] = 1'b1;
                            out_ld         = 1'b1;
                        end
                        OP_HLT: begin
                            halt_set = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    st_nxt = T0;
                    case (opcode)
                        OP_LDA: begin
                            bus_sel[SRC_RAM] = 1'b1;
                            a_ld             = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus_sel[SRC_RAM] = 1'b1;
                            b_ld             = 1'b1;
                            st_nxt           = T4;
                        end
                        OP_STA: begin
                            bus_sel[SRC_A] = 1'b1;
                            ram_we         = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    alu_sub          = (opcode == OP_SUB);
                    bus_sel[SRC_ALU] = 1'b1;
                    a_ld             = 1'b1;
                    flags_ld         = 1'b1;
                    st_nxt           = T0;
                end
                default: st_nxt = T0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st <= T0;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc        <= '0;
            mar       <= '0;
            a_data    <= '0;
            b_data    <= '0;
            ir_data   <= '0;
            out_data  <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (mar_ld)   mar      <= bus[ADDR_W-1:0];
            if (ir_ld)    ir_data  <= bus;
            if (pc_inc)   pc       <= pc + ADDR_W'(1);
            else if (pc_ld) pc     <= bus[ADDR_W-1:0];
            if (a_ld)     a_data   <= bus;
            if (b_ld)     b_data   <= bus;
            if (out_ld)   out_data <= bus;
            if (flags_ld) begin
                carry <= sum[DATA_W];
                zero  <= (sum[DATA_W-1:0] == '0);
            end
            out_valid <= out_ld;
            if (halt_set) halted <= 1'b1;
        end
    end

    // Program loads are only accepted while the core is not executing,
    // so they can never collide with an STA write.
    always_ff @(posedge clk) begin
        if (prog_we && (clr || halted)) begin
            ram[prog_addr] <= prog_data;
        end else if (ram_we) begin
            ram[mar] <= bus;
        end
    end

    assign flags = {carry, zero};
    assign step  = st;

endmodule

// File: tb/tb_sap_cpu_param.sv
module tb_sap_cpu_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8/4 instance
    logic       clr = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [7:0] out_data, a_data, b_data, ir_data;
    logic       out_valid, halted;
    logic [3:0] pc;
    logic [1:0] flags;
    logic [2:0] step;

    sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) u_dut (
        .clk(clk), .clr(clr), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_data(out_data), .out_valid(out_valid), .halted(halted), .pc(pc),
        .a_data(a_data), .b_data(b_data), .ir_data(ir_data), .flags(flags), .step(step)
    );

    // 12/8 instance
    logic        clr2 = 1'b0;
    logic        prog_we2 = 1'b0;
    logic [7:0]  prog_addr2 = '0;
    logic [11:0] prog_data2 = '0;
    logic [11:0] out_data2, a_data2, b_data2, ir_data2;
    logic        out_valid2, halted2;
    logic [7:0]  pc2;
    logic [1:0]  flags2;
    logic [2:0]  step2;

    sap_cpu_param #(.DATA_W(12), .ADDR_W(8)) u_dut2 (
        .clk(clk), .clr(clr2), .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
        .out_data(out_data2), .out_valid(out_valid2), .halted(halted2), .pc(pc2),
        .a_data(a_data2), .b_data(b_data2), .ir_data(ir_data2), .flags(flags2), .step(step2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ISA-level reference model: one call executes one whole instruction
    logic [7:0] m_mem [16];
    logic [7:0] m_a, m_b, m_ir, m_out;
    logic [3:0] m_pc;
    logic       m_c, m_z, m_halt;
    logic [7:0] p_words [16];

    task automatic m_reset();
        m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_pc = 0;
        m_c = 0; m_z = 0; m_halt = 0;
    endtask

    task automatic m_exec(output int cyc, output int pulses);
        logic [3:0] op, opr;
        int s;
        m_ir = m_mem[m_pc];
        m_pc = m_pc + 4'd1;
        op   = m_ir[7:4];
        opr  = m_ir[3:0];
        pulses = 0;
        cyc    = 3;
        case (op)
            4'h1: begin m_a = m_mem[opr]; cyc = 4; end
            4'h2: begin
                m_b = m_mem[opr];
                s = int'(m_a) + int'(m_b);
                m_c = (s > 255);
                m_a = s[7:0];
                m_z = (m_a == 0);
                cyc = 5;
            end
            4'h3: begin
                m_b = m_mem[opr];
                m_c = (m_a >= m_b);
                m_a = m_a - m_b;
                m_z = (m_a == 0);
                cyc = 5;
            end
            4'h4: begin m_mem[opr] = m_a; cyc = 4; end
            4'h5: m_a = {4'h0, opr};
            4'h6: m_pc = opr;
            4'h7: if (m_c) m_pc = opr;
            4'h8: if (m_z) m_pc = opr;
            4'hE: begin m_out = m_a; pulses = 1; end
            4'hF: m_halt = 1;
            default: cyc = 2;
        endcase
    endtask

    task automatic cmp_state(input string tag);
        chk({tag, ".pc"},    pc,        m_pc);
        chk({tag, ".a"},     a_data,    m_a);
        chk({tag, ".b"},     b_data,    m_b);
        chk({tag, ".ir"},    ir_data,   m_ir);
        chk({tag, ".out"},   out_data,  m_out);
        chk({tag, ".flags"}, flags,     {m_c, m_z});
        chk({tag, ".step"},  step,      3'd0);
        chk({tag, ".halt"},  halted,    m_halt);
    endtask

    task automatic load_words();
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = i[3:0];
            prog_data = p_words[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = p_words[i];
    endtask

    // Called #1 after a posedge. Loads p_words (via the halted path if
    // allowed), resets the core mid-cycle, and releases clr.
    task automatic setup_prog(input bit via_halt);
        if (via_halt && m_halt) begin
            load_words();
            #2 clr = 1'b1;
            #1 chk("rst_async_pc", pc, 4'd0);
            @(posedge clk); #1;
        end else begin
            #2 clr = 1'b1;
            #1 chk("rst_async_pc", pc, 4'd0);
            chk("rst_async_step", step, 3'd0);
            @(posedge clk); #1;
            load_words();
        end
        m_reset();
        cmp_state("reset");
        chk("reset.outv", out_valid, 1'b0);
        clr = 1'b0;
    endtask

    task automatic run_instrs(input int max_n);
        int cyc, pul, seen;
        for (int n = 0; n < max_n && !m_halt; n++) begin
            m_exec(cyc, pul);
            seen = 0;
            for (int i = 0; i < cyc; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
                // Scribble on the load port while running; it must be ignored.
                if (m_halt && i == cyc - 1) begin
                    prog_we = 1'b0;
                end else begin
                    prog_we   = 1'b1;
                    prog_addr = 4'($urandom_range(0, 15));
                    prog_data = 8'($urandom_range(0, 255));
                end
            end
            chk("outv_pulses", seen, pul);
            cmp_state("instr");
        end
        prog_we = 1'b0;
    endtask

    task automatic freeze_check();
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("freeze_outv", seen, 0);
        cmp_state("freeze");
    endtask

    initial begin
        int cyc2;
        int exp_cyc2;

        #2 clr = 1'b1; clr2 = 1'b1;
        #1;
        m_reset();
        cmp_state("por");
        chk("por.outv", out_valid, 1'b0);
        @(posedge clk); #1;

        // Idle: all NOPs, PC steps every 2 clks and wraps
        for (int i = 0; i < 16; i++) p_words[i] = 8'h00;
        setup_prog(1'b0);
        run_instrs(20);
        chk("idle_wrap_pc", pc, 4'd4);

        // Add/out: 28 + 14 = 42
        for (int i = 0; i < 16; i++) p_words[i] = 8'h00;
        p_words[0] = 8'h1E; p_words[1] = 8'h2F; p_words[2] = 8'hE0; p_words[3] = 8'hF0;
        p_words[14] = 8'd28; p_words[15] = 8'd14;
        setup_prog(1'b0);
        run_instrs(10);
        chk("addout_val", out_data, 8'd42);
        chk("addout_halt", halted, 1'b1);
        chk("addout_flags", flags, 2'b00);
        freeze_check();

        // Carry/zero, JC taken, JZ not taken, STA/LDA round trip (loaded while halted)
        for (int i = 0; i < 16; i++) p_words[i] = 8'h00;
        p_words[0] = 8'h5F; p_words[1] = 8'h2E; p_words[2] = 8'h74; p_words[3] = 8'hF0;
        p_words[4] = 8'h3D; p_words[5] = 8'h89; p_words[6] = 8'h4C; p_words[7] = 8'h53;
        p_words[8] = 8'h1C; p_words[9] = 8'hE0; p_words[10] = 8'hF0;
        p_words[13] = 8'd1; p_words[14] = 8'd241;
        setup_prog(1'b1);
        run_instrs(3);
        chk("cz_add_a", a_data, 8'd0);
        chk("cz_add_flags", flags, 2'b11);
        chk("cz_jc_taken_pc", pc, 4'd4);
        run_instrs(2);
        chk("cz_sub_a", a_data, 8'd255);
        chk("cz_sub_flags", flags, 2'b00);
        chk("cz_jz_not_taken_pc", pc, 4'd6);
        run_instrs(20);
        chk("sta_lda_out", out_data, 8'd255);
        freeze_check();

        // Randomized programs
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) p_words[i] = 8'($urandom_range(0, 255));
            setup_prog(1'($urandom_range(0, 1)));
            run_instrs(40);
        end

        // 12/8 counter loop: ADD one / JC exit / JMP 0, exit is HLT at 5
        #2 clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1;
        prog_we2 = 1'b1;
        prog_addr2 = 8'h00; prog_data2 = 12'h210; @(posedge clk); #1;
        prog_addr2 = 8'h01; prog_data2 = 12'h705; @(posedge clk); #1;
        prog_addr2 = 8'h02; prog_data2 = 12'h600; @(posedge clk); #1;
        prog_addr2 = 8'h05; prog_data2 = 12'hF00; @(posedge clk); #1;
        prog_addr2 = 8'h10; prog_data2 = 12'h001; @(posedge clk); #1;
        prog_we2 = 1'b0;
        clr2 = 1'b0;
        cyc2 = 0;
        while (!halted2 && cyc2 < 60000) begin
            @(posedge clk); #1;
            cyc2++;
        end
        // 4095 non-carry iterations of 11 clks, final ADD+JC (8), then HLT (3)
        exp_cyc2 = 4095 * 11 + 8 + 3;
        chk("sweep_halted", halted2, 1'b1);
        chk("sweep_cycles", cyc2, exp_cyc2);
        chk("sweep_a", a_data2, 12'd0);
        chk("sweep_flags", flags2, 2'b11);
        chk("sweep_pc", pc2, 8'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
